// File: rtl/data_mem_sync_pkg.sv
// Shared definitions for the synchronous data memory: access sizes, FSM states
// and the default placement of the data region.
package data_mem_sync_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h1800;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: alignment check, byte enables and store-lane
// shifting for the request, plus lane extraction and sign/zero extension for loads.
module mem_lane_align
  import data_mem_sync_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NB   = XLEN / 8,
  parameter int unsigned LW   = $clog2(NB)
) (
  input  logic [1:0]      size,
  input  logic [LW-1:0]   lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      rd_size,
  input  logic [LW-1:0]   rd_lane,
  input  logic            rd_unsigned,
  input  logic [XLEN-1:0] rd_word,
  output logic            misaligned,
  output logic [NB-1:0]   byte_en,
  output logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd_ext
);

  logic [LW-1:0]   align_mask;
  logic [NB-1:0]   lane_mask;
  logic [XLEN-1:0] shifted;
  logic            fill;

  always_comb begin
    align_mask = LW'((32'd1 << size) - 32'd1);
    lane_mask  = NB'((32'd1 << (32'd1 << size)) - 32'd1);
    misaligned = (lane & align_mask) != '0;
    byte_en    = lane_mask << lane;
    wr_data    = wdata << {lane, 3'b000};

    shifted = rd_word >> {rd_lane, 3'b000};
    fill    = 1'b0;
    rd_ext  = shifted;
    case (size_t'(rd_size))
      SZ_B: begin
        fill   = ~rd_unsigned & shifted[7];
        rd_ext = {{(XLEN-8){fill}}, shifted[7:0]};
      end
      SZ_H: begin
        fill   = ~rd_unsigned & shifted[15];
        rd_ext = {{(XLEN-16){fill}}, shifted[15:0]};
      end
      SZ_W: begin
        fill   = ~rd_unsigned & shifted[31];
        rd_ext = {{(XLEN-32){fill}}, shifted[31:0]};
      end
      default: rd_ext = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_sync.sv
// Byte-addressable little-endian data memory with one-cycle load latency,
// fault reporting, and a post-reset clearing sweep that zeroes every word.
module data_mem_sync
  import data_mem_sync_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     DEPTH     = 1280,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(DEFAULT_BASE_ADDR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            fault,
  output logic            busy
);

  localparam int unsigned     NB   = XLEN / 8;
  localparam int unsigned     LW   = $clog2(NB);
  localparam int unsigned     IW   = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH) << LW;

  logic [XLEN-1:0] mem [DEPTH];

  state_t          state;
  logic [IW-1:0]   clr_idx;
  logic [XLEN-1:0] offset;
  logic [IW-1:0]   idx;
  logic            ready, in_range, misaligned, req_ok;
  logic            do_load, do_store, req_fault;
  logic [NB-1:0]   byte_en;
  logic [XLEN-1:0] lane_wdata, rd_word, rd_ext;
  logic [1:0]      rd_size;
  logic [LW-1:0]   rd_lane;
  logic            rd_unsigned;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [NB-1:0]   wr_be;
  logic [XLEN-1:0] wr_data;

  assign offset    = addr - BASE_ADDR;
  assign idx       = offset[LW +: IW];
  assign ready     = (state == ST_READY) && !rst;
  assign in_range  = (addr >= BASE_ADDR) && (offset < SPAN);
  assign req_ok    = in_range && !misaligned && !(mem_read && mem_write);
  assign do_load   = ready && mem_read && !mem_write && req_ok;
  assign do_store  = ready && mem_write && !mem_read && req_ok;
  assign req_fault = ready && (mem_read || mem_write) && !req_ok;

  mem_lane_align #(.XLEN(XLEN), .NB(NB), .LW(LW)) u_align (
    .size        (size),
    .lane        (addr[LW-1:0]),
    .wdata       (wdata),
    .rd_size     (rd_size),
    .rd_lane     (rd_lane),
    .rd_unsigned (rd_unsigned),
    .rd_word     (rd_word),
    .misaligned  (misaligned),
    .byte_en     (byte_en),
    .wr_data     (lane_wdata),
    .rd_ext      (rd_ext)
  );

  // Single write port shared by the clearing sweep and stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_be   = byte_en;
    wr_data = lane_wdata;
    if (state == ST_CLEAR) begin
      wr_en   = !rst;
      wr_idx  = clr_idx;
      wr_be   = '1;
      wr_data = '0;
    end else begin
      wr_en = do_store;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_en && wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  // The raw word is registered and extension happens after the register, so
  // the array keeps a plain registered read port and rdata holds between loads.
  always_ff @(posedge clk) begin
    if (rst)          rd_word <= '0;
    else if (do_load) rd_word <= mem[idx];
  end

  assign rdata = rd_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      clr_idx     <= '0;
      busy        <= 1'b1;
      rvalid      <= 1'b0;
      fault       <= 1'b0;
      rd_size     <= SZ_D;
      rd_lane     <= '0;
      rd_unsigned <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          rvalid  <= 1'b0;
          fault   <= 1'b0;
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IW'(DEPTH - 1)) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        default: begin
          rvalid <= do_load;
          fault  <= req_fault;
          if (do_load) begin
            rd_size     <= size;
            rd_lane     <= addr[LW-1:0];
            rd_unsigned <= load_unsigned;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed self-checking bench for data_mem_sync: clearing sweep, loads/stores
// of every size, fault cases and reset during clearing.
module tb_data_mem_sync;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, load_unsigned;
  logic [1:0]  size;
  logic [63:0] addr, wdata, rdata;
  logic        rvalid, fault, busy;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  data_mem_sync #(.XLEN(64), .DEPTH(1280), .BASE_ADDR(64'h1800)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .size          (size),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .fault         (fault),
    .busy          (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [63:0] a, input logic [63:0] wd);
    mem_read      = rd;
    mem_write     = wr;
    size          = sz;
    load_unsigned = uns;
    addr          = a;
    wdata         = wd;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [63:0] a, input logic [63:0] wd);
    drive(rd, wr, sz, uns, a, wd);
    step();
    idle();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle();
    step();
    nchecks++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL reset_busy got=%b exp=1", busy); end
    nchecks++;
    if (rvalid !== 1'b0) begin nerr++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    nchecks++;
    if (fault !== 1'b0) begin nerr++; $display("FAIL reset_fault got=%b exp=0", fault); end
    nchecks++;
    if (rdata !== 64'h0) begin nerr++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    rst = 1'b0;
    wait_clear(n);
    nchecks++;
    if (n != 1280) begin nerr++; $display("FAIL clear_cycles got=%0d exp=1280", n); end
    issue(1, 0, 2'd3, 0, 64'h1800, 64'h0);
    nchecks++;
    if (rvalid !== 1'b1 || rdata !== 64'h0) begin
      nerr++; $display("FAIL clear_load rvalid=%b rdata=%h exp rvalid=1 rdata=0", rvalid, rdata);
    end
  endtask

  task automatic test_store_load();
    logic [1:0]  sz  [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
    logic        uns [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] a   [6] = '{64'h1803, 64'h1806, 64'h1804, 64'h1804, 64'h1807, 64'h1800};
    logic [63:0] exp [6] = '{64'h44, 64'hFFFF_FFFF_FFFF_8877, 64'hFFFF_FFFF_8877_6655,
                             64'h8877_6655, 64'hFFFF_FFFF_FFFF_FF88, 64'h2211};
    issue(0, 1, 2'd3, 0, 64'h1800, 64'h8877665544332211);
    nchecks++;
    if (fault !== 1'b0 || rvalid !== 1'b0) begin
      nerr++; $display("FAIL store_d fault=%b rvalid=%b exp 0 0", fault, rvalid);
    end
    for (int i = 0; i < 6; i++) begin
      issue(1, 0, sz[i], uns[i], a[i], 64'h0);
      nchecks++;
      if (rvalid !== 1'b1 || rdata !== exp[i]) begin
        nerr++; $display("FAIL load_%0d rvalid=%b rdata=%h exp rvalid=1 rdata=%h", i, rvalid, rdata, exp[i]);
      end
    end
    step();
    nchecks++;
    if (rvalid !== 1'b0 || rdata !== 64'h2211) begin
      nerr++; $display("FAIL rdata_hold rvalid=%b rdata=%h exp rvalid=0 rdata=2211", rvalid, rdata);
    end
  endtask

  task automatic test_partial_store();
    issue(0, 1, 2'd0, 0, 64'h1801, 64'hFFFF_FFFF_FFFF_FFAB);
    nchecks++;
    if (fault !== 1'b0) begin nerr++; $display("FAIL store_b fault=%b exp=0", fault); end
    issue(1, 0, 2'd3, 0, 64'h1800, 64'h0);
    nchecks++;
    if (rvalid !== 1'b1 || rdata !== 64'h887766554433AB11) begin
      nerr++; $display("FAIL store_b_readback rvalid=%b rdata=%h exp 887766554433ab11", rvalid, rdata);
    end
    issue(0, 1, 2'd1, 0, 64'h180A, 64'h1111_CAFE);
    issue(1, 0, 2'd3, 0, 64'h1808, 64'h0);
    nchecks++;
    if (rvalid !== 1'b1 || rdata !== 64'h0000_0000_CAFE_0000) begin
      nerr++; $display("FAIL store_h_readback rvalid=%b rdata=%h exp 00000000cafe0000", rvalid, rdata);
    end
    issue(0, 1, 2'd2, 0, 64'h3FFC, 64'h0123_4567_DEAD_BEEF);
    issue(1, 0, 2'd2, 1, 64'h3FFC, 64'h0);
    nchecks++;
    if (rvalid !== 1'b1 || rdata !== 64'hDEAD_BEEF) begin
      nerr++; $display("FAIL last_word rvalid=%b rdata=%h exp deadbeef", rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz  [4] = '{2'd0, 2'd3, 2'd1, 2'd2};
    logic        uns [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] a   [4] = '{64'h1803, 64'h1808, 64'h180A, 64'h3FFC};
    logic [63:0] exp [4] = '{64'h44, 64'hCAFE_0000, 64'hFFFF_FFFF_FFFF_CAFE, 64'hFFFF_FFFF_DEAD_BEEF};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, sz[i], uns[i], a[i], 64'h0);
      step();
      nchecks++;
      if (rvalid !== 1'b1 || rdata !== exp[i]) begin
        nerr++; $display("FAIL b2b_%0d rvalid=%b rdata=%h exp rvalid=1 rdata=%h", i, rvalid, rdata, exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_faults();
    logic        rd  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        wr  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  sz  [6] = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd3, 2'd0};
    logic [63:0] a   [6] = '{64'h1802, 64'h17F8, 64'h4000, 64'h1801, 64'h1808, 64'h4000};
    for (int i = 0; i < 6; i++) begin
      issue(rd[i], wr[i], sz[i], 0, a[i], 64'hFFFF_FFFF_FFFF_FFFF);
      nchecks++;
      if (fault !== 1'b1 || rvalid !== 1'b0 || rdata !== 64'hFFFF_FFFF_DEAD_BEEF) begin
        nerr++; $display("FAIL fault_%0d fault=%b rvalid=%b rdata=%h exp 1 0 ffffffffdeadbeef",
                         i, fault, rvalid, rdata);
      end
    end
    step();
    nchecks++;
    if (fault !== 1'b0) begin nerr++; $display("FAIL fault_pulse fault=%b exp=0", fault); end
    issue(1, 0, 2'd3, 0, 64'h1800, 64'h0);
    nchecks++;
    if (rdata !== 64'h887766554433AB11) begin
      nerr++; $display("FAIL fault_nowrite_1800 rdata=%h exp 887766554433ab11", rdata);
    end
    issue(1, 0, 2'd3, 0, 64'h1808, 64'h0);
    nchecks++;
    if (rdata !== 64'hCAFE_0000) begin
      nerr++; $display("FAIL conflict_nowrite rdata=%h exp cafe0000", rdata);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    issue(0, 1, 2'd3, 0, 64'h1810, 64'h5555);
    rst = 1'b1;
    step();
    rst = 1'b0;
    nchecks++;
    if (rdata !== 64'h0 || busy !== 1'b1) begin
      nerr++; $display("FAIL rst_rdata rdata=%h busy=%b exp 0 1", rdata, busy);
    end
    for (int i = 0; i < 500; i++) begin
      if (i == 100) drive(1, 0, 2'd3, 0, 64'h1810, 64'h0);
      step();
      if (i == 100) begin
        idle();
        nchecks++;
        if (rvalid !== 1'b0 || fault !== 1'b0 || busy !== 1'b1) begin
          nerr++; $display("FAIL clear_ignores rvalid=%b fault=%b busy=%b exp 0 0 1", rvalid, fault, busy);
        end
      end
    end
    drive(0, 1, 2'd3, 0, 64'h1818, 64'h9999);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    nchecks++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || fault !== 1'b0) begin
      nerr++; $display("FAIL rst_mid busy=%b rvalid=%b fault=%b exp 1 0 0", busy, rvalid, fault);
    end
    wait_clear(n);
    nchecks++;
    if (n != 1280) begin nerr++; $display("FAIL reclear_cycles got=%0d exp=1280", n); end
    issue(1, 0, 2'd3, 0, 64'h1810, 64'h0);
    nchecks++;
    if (rvalid !== 1'b1 || rdata !== 64'h0) begin
      nerr++; $display("FAIL cleared_1810 rvalid=%b rdata=%h exp 1 0", rvalid, rdata);
    end
    issue(1, 0, 2'd3, 0, 64'h1818, 64'h0);
    nchecks++;
    if (rvalid !== 1'b1 || rdata !== 64'h0) begin
      nerr++; $display("FAIL discarded_store rvalid=%b rdata=%h exp 1 0", rvalid, rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'd0, 0, 64'h0, 64'h0);
    test_reset();
    test_store_load();
    test_partial_store();
    test_back_to_back();
    test_faults();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
